// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared playfield defaults, piece/cell types, command codes
//                and the 7x4x4 tetromino shape-offset table.
//                Table entry layout: {dx[1:0], dy[1:0]} inside the 4x4 box,
//                four cells per rotation, ordered row-major (dy, then dx).
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

  localparam int c_rows_def = 10;
  localparam int c_cols_def = 10;

  typedef enum logic [2:0] {
    PC_I    = 3'd0,
    PC_O    = 3'd1,
    PC_T    = 3'd2,
    PC_S    = 3'd3,
    PC_Z    = 3'd4,
    PC_J    = 3'd5,
    PC_L    = 3'd6,
    PC_NONE = 3'd7
  } piece_e;

  // Grid cell contents: 0 = empty, otherwise piece_type+1.
  typedef logic [2:0] cell_t;

  localparam logic [1:0] c_cmd_check = 2'b01;
  localparam logic [1:0] c_cmd_lock  = 2'b10;

  // [piece][rotation][cell] -> {dx,dy}; hex digit = dx*4 + dy.
  localparam logic [3:0] c_shape_tab [0:6][0:3][0:3] = '{
    // I
    '{ '{4'h1, 4'h5, 4'h9, 4'hD}, '{4'h8, 4'h9, 4'hA, 4'hB},
       '{4'h2, 4'h6, 4'hA, 4'hE}, '{4'h4, 4'h5, 4'h6, 4'h7} },
    // O
    '{ '{4'h5, 4'h9, 4'h6, 4'hA}, '{4'h5, 4'h9, 4'h6, 4'hA},
       '{4'h5, 4'h9, 4'h6, 4'hA}, '{4'h5, 4'h9, 4'h6, 4'hA} },
    // T
    '{ '{4'h4, 4'h1, 4'h5, 4'h9}, '{4'h4, 4'h5, 4'h9, 4'h6},
       '{4'h1, 4'h5, 4'h9, 4'h6}, '{4'h4, 4'h1, 4'h5, 4'h6} },
    // S
    '{ '{4'h4, 4'h8, 4'h1, 4'h5}, '{4'h4, 4'h5, 4'h9, 4'hA},
       '{4'h5, 4'h9, 4'h2, 4'h6}, '{4'h0, 4'h1, 4'h5, 4'h6} },
    // Z
    '{ '{4'h0, 4'h4, 4'h5, 4'h9}, '{4'h8, 4'h5, 4'h9, 4'h6},
       '{4'h1, 4'h5, 4'h6, 4'hA}, '{4'h4, 4'h1, 4'h5, 4'h2} },
    // J
    '{ '{4'h0, 4'h1, 4'h5, 4'h9}, '{4'h4, 4'h8, 4'h5, 4'h6},
       '{4'h1, 4'h5, 4'h9, 4'hA}, '{4'h4, 4'h5, 4'h2, 4'h6} },
    // L
    '{ '{4'h8, 4'h1, 4'h5, 4'h9}, '{4'h4, 4'h5, 4'h6, 4'hA},
       '{4'h1, 4'h5, 4'h9, 4'h2}, '{4'h0, 4'h4, 4'h5, 4'h6} }
  };

endpackage
`default_nettype wire

// File: rtl/tetromino_rom.sv
`default_nettype none
// ============================================================================
//  Module      : tetromino_rom
//  Description : Combinational shape lookup. Returns the (dx,dy) offset of
//                one cell of a tetromino inside its 4x4 box.
//  Ports       : piece_type_i - tetromino 0..6 (7 returns offset 0,0)
//                rot_i        - rotation 0..3
//                idx_i        - cell index 0..3
//                dx_o, dy_o   - column / row offset in the box
//  Revision    : 1.0 - initial release
// ============================================================================
module tetromino_rom
  import tetris_pkg::*;
(
  input  logic [2:0] piece_type_i,
  input  logic [1:0] rot_i,
  input  logic [1:0] idx_i,
  output logic [1:0] dx_o,
  output logic [1:0] dy_o
);

  logic [3:0] w_ent;

  always_comb begin
    w_ent = 4'h0;
    if (piece_type_i != PC_NONE) begin
      w_ent = c_shape_tab[piece_type_i][rot_i][idx_i];
    end
  end

  assign dx_o = w_ent[3:2];
  assign dy_o = w_ent[1:0];

endmodule
`default_nettype wire

// File: rtl/piece_placer.sv
`default_nettype none
// ============================================================================
//  Module      : piece_placer
//  Description : Checks a tetromino placement against an external grid and,
//                for lock commands without collision, writes its cells.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                cmd_valid, cmd        - command strobe (01 check, 10 lock)
//                piece_type, rot       - tetromino 0..6 and rotation 0..3
//                px, py                - signed origin of the 4x4 shape box
//                rd_row, rd_colum      - grid read address
//                rd_data               - grid read data (one-cycle latency)
//                wr_en/wr_row/wr_colum - grid write strobe and address
//                wr_data               - written cell value (piece_type+1)
//                busy, done            - activity flag and completion pulse
//                collide, overflow     - placement result flags
//  Revision    : 1.0 - initial release
// ============================================================================
module piece_placer
  import tetris_pkg::*;
#(
  parameter int ROWS = c_rows_def,
  parameter int COLS = c_cols_def
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [2:0] piece_type,
  input  logic [1:0] rot,
  input  logic [4:0] px,
  input  logic [4:0] py,
  output logic [3:0] rd_row,
  output logic [3:0] rd_colum,
  input  logic [2:0] rd_data,
  output logic       wr_en,
  output logic [3:0] wr_row,
  output logic [3:0] wr_colum,
  output logic [2:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       collide,
  output logic       overflow
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_check = 2'd1;
  localparam logic [1:0] c_st_write = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic signed [5:0] c_row_max = 6'(ROWS - 1);
  localparam logic signed [5:0] c_col_max = 6'(COLS - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic [2:0] ptype_q, ptype_d;
  logic [1:0] rot_q, rot_d;
  logic [4:0] px_q, px_d;
  logic [4:0] py_q, py_d;
  logic       coll_q, coll_d;
  logic       ovf_q, ovf_d;
  // Classification of the cell addressed last cycle, evaluated this cycle
  // when its rd_data arrives.
  logic       pend_q, pend_d;
  logic       pend_bad_q, pend_bad_d;  // collides regardless of grid contents
  logic       pend_rd_q, pend_rd_d;    // collides if the grid cell is occupied

  logic [1:0]        w_dx, w_dy;
  logic signed [5:0] w_row, w_col;
  logic              w_col_ok, w_row_neg, w_row_hi, w_row_ok;
  logic              w_accept, w_hit;
  cell_t             w_cell_val;

  // One ROM serves both phases: the counter selects the cell being
  // addressed in CHECK and the cell being written in WRITE.
  tetromino_rom u_rom (
    .piece_type_i (ptype_q),
    .rot_i        (rot_q),
    .idx_i        (cnt_q[1:0]),
    .dx_o         (w_dx),
    .dy_o         (w_dy)
  );

  assign w_row = $signed({py_q[4], py_q}) + $signed({4'b0000, w_dy});
  assign w_col = $signed({px_q[4], px_q}) + $signed({4'b0000, w_dx});

  assign w_col_ok  = (w_col >= 6'sd0) && (w_col <= c_col_max);
  assign w_row_neg = (w_row < 6'sd0);
  assign w_row_hi  = (w_row > c_row_max);
  assign w_row_ok  = !w_row_neg && !w_row_hi;

  assign w_accept = cmd_valid && ((cmd == c_cmd_check) || (cmd == c_cmd_lock)) &&
                    (piece_type != PC_NONE);
  assign w_hit    = pend_q && (pend_bad_q || (pend_rd_q && (rd_data != '0)));
  assign w_cell_val = ptype_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    ptype_d    = ptype_q;
    rot_d      = rot_q;
    px_d       = px_q;
    py_d       = py_q;
    coll_d     = coll_q;
    ovf_d      = ovf_q;
    pend_d     = 1'b0;
    pend_bad_d = 1'b0;
    pend_rd_d  = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (w_accept) begin
          state_d = c_st_check;
          cnt_d   = '0;
          cmd_d   = cmd;
          ptype_d = piece_type;
          rot_d   = rot;
          px_d    = px;
          py_d    = py;
          coll_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      c_st_check: begin
        coll_d = coll_q | w_hit;
        cnt_d  = cnt_q + 3'd1;
        if (!cnt_q[2]) begin
          pend_d     = 1'b1;
          pend_bad_d = !w_col_ok || w_row_hi;
          pend_rd_d  = w_col_ok && w_row_ok;
        end else begin
          // Count 4 evaluates the last cell; decide on the full result.
          cnt_d = '0;
          if ((cmd_q == c_cmd_lock) && !coll_d) begin
            state_d = c_st_write;
          end else begin
            state_d = c_st_done;
          end
        end
      end
      c_st_write: begin
        if (w_row_neg) begin
          ovf_d = 1'b1;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q[1:0] == 2'd3) begin
          state_d = c_st_done;
          cnt_d   = '0;
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      cnt_q      <= '0;
      cmd_q      <= '0;
      ptype_q    <= '0;
      rot_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      coll_q     <= 1'b0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_bad_q <= 1'b0;
      pend_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      ptype_q    <= ptype_d;
      rot_q      <= rot_d;
      px_q       <= px_d;
      py_q       <= py_d;
      coll_q     <= coll_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      pend_bad_q <= pend_bad_d;
      pend_rd_q  <= pend_rd_d;
    end
  end

  // Grid ports are combinational from state so they are zero whenever the
  // machine is idle. The write strobe is also masked by rst so a write slot
  // coinciding with a reset cycle is abandoned rather than committed.
  always_comb begin
    rd_row   = '0;
    rd_colum = '0;
    wr_en    = 1'b0;
    wr_row   = '0;
    wr_colum = '0;
    wr_data  = '0;
    if ((state_q == c_st_check) && !cnt_q[2] && w_row_ok && w_col_ok) begin
      rd_row   = w_row[3:0];
      rd_colum = w_col[3:0];
    end
    if ((state_q == c_st_write) && !rst) begin
      wr_data = w_cell_val;
      if (!w_row_neg) begin
        wr_en    = 1'b1;
        wr_row   = w_row[3:0];
        wr_colum = w_col[3:0];
      end
    end
  end

  assign busy     = (state_q != c_st_idle);
  assign done     = (state_q == c_st_done);
  assign collide  = coll_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_piece_placer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piece_placer
//  Description : Directed bench for piece_placer with a grid memory model
//                and queues of expected reads, writes and results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piece_placer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [2:0] piece_type;
  logic [1:0] rot;
  logic [4:0] px, py;
  logic [3:0] rd_row, rd_colum;
  logic [2:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_row, wr_colum;
  logic [2:0] wr_data;
  logic       busy, done, collide, overflow;

  always #5 clk = ~clk;

  piece_placer #(.ROWS(10), .COLS(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .piece_type(piece_type), .rot(rot), .px(px), .py(py),
    .rd_row(rd_row), .rd_colum(rd_colum), .rd_data(rd_data),
    .wr_en(wr_en), .wr_row(wr_row), .wr_colum(wr_colum), .wr_data(wr_data),
    .busy(busy), .done(done), .collide(collide), .overflow(overflow)
  );

  // Grid memory model: one-cycle read latency, write on wr_en.
  logic [2:0] grid [0:9][0:9];
  logic       gclr;
  logic       gset;
  int         gset_r, gset_c;
  logic [2:0] gset_v;

  always @(posedge clk) begin
    if (rd_row < 4'd10 && rd_colum < 4'd10) rd_data <= grid[rd_row][rd_colum];
    else rd_data <= 3'd0;
    if (gclr) begin
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++) grid[r][c] <= 3'd0;
    end else if (gset) begin
      grid[gset_r][gset_c] <= gset_v;
    end
    if (wr_en && wr_row < 4'd10 && wr_colum < 4'd10) grid[wr_row][wr_colum] <= wr_data;
  end

  int errors = 0;
  int checks = 0;

  typedef struct { int cyc; int row; int col; int data; } wr_t;
  typedef struct { int cyc; int coll; int ovf; } res_t;
  typedef struct { int cyc; int row; int col; } rd_t;

  wr_t  exp_wr_q[$];
  res_t exp_res_q[$];
  rd_t  exp_rd_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_wr(input int cy, input int r, input int c, input int d);
    wr_t e;
    e.cyc = cy; e.row = r; e.col = c; e.data = d;
    exp_wr_q.push_back(e);
  endtask

  task automatic push_res(input int cy, input int cl, input int ov);
    res_t e;
    e.cyc = cy; e.coll = cl; e.ovf = ov;
    exp_res_q.push_back(e);
  endtask

  task automatic push_rd(input int cy, input int r, input int c);
    rd_t e;
    e.cyc = cy; e.row = r; e.col = c;
    exp_rd_q.push_back(e);
  endtask

  task automatic clear_grid();
    @(negedge clk); gclr = 1'b1;
    @(negedge clk); gclr = 1'b0;
  endtask

  // Issue one command (cycle 0 = acceptance cycle) and compare everything
  // observed up to done against the queued expectations. With hold_busy,
  // a conflicting command is held on the inputs during cycles 1..2.
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic [2:0] pt,
                         input logic [1:0] r, input int x, input int y, input bit hold_busy);
    wr_t  ew;
    res_t er;
    rd_t  erd;
    bit   seen;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; piece_type = pt; rot = r;
    px = 5'(x); py = 5'(y);
    @(posedge clk); #1;
    if (hold_busy) begin
      cmd = 2'b10; piece_type = 3'd2; px = 5'd0; py = 5'd0;
    end else begin
      cmd_valid = 1'b0;
    end
    seen = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 3) cmd_valid = 1'b0;
      if (cyc == 1) chk({tag, ".busy"}, busy, 1);
      if (exp_rd_q.size() > 0 && exp_rd_q[0].cyc == cyc) begin
        erd = exp_rd_q.pop_front();
        chk({tag, ".rd_row"}, rd_row, erd.row);
        chk({tag, ".rd_colum"}, rd_colum, erd.col);
      end
      if (wr_en) begin
        if (exp_wr_q.size() == 0) begin
          chk({tag, ".unexpected_wr_en"}, wr_en, 0);
        end else begin
          ew = exp_wr_q.pop_front();
          chk({tag, ".wr_cycle"}, cyc, ew.cyc);
          chk({tag, ".wr_row"}, wr_row, ew.row);
          chk({tag, ".wr_colum"}, wr_colum, ew.col);
          chk({tag, ".wr_data"}, wr_data, ew.data);
        end
      end
      if (done) begin
        seen = 1'b1;
        if (exp_res_q.size() == 0) begin
          chk({tag, ".unexpected_done"}, done, 0);
        end else begin
          er = exp_res_q.pop_front();
          chk({tag, ".done_cycle"}, cyc, er.cyc);
          chk({tag, ".collide"}, collide, er.coll);
          chk({tag, ".overflow"}, overflow, er.ovf);
        end
      end
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".writes_missing"}, exp_wr_q.size(), 0);
    exp_wr_q.delete();
    exp_res_q.delete();
    exp_rd_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd = 2'b01; piece_type = 3'd0; rot = 2'd0;
    px = 5'd0; py = 5'd0; gclr = 1'b1; gset = 1'b0; gset_r = 0; gset_c = 0; gset_v = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state, with a valid command held during reset.
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.collide", collide, 0);
    chk("rst.overflow", overflow, 0);
    chk("rst.wr_en", wr_en, 0);
    chk("rst.rd_row", rd_row, 0);
    chk("rst.wr_data", wr_data, 0);
    rst = 1'b0; gclr = 1'b0; cmd_valid = 1'b0;

    // No-op commands are not accepted.
    @(negedge clk); cmd_valid = 1'b1; cmd = 2'b00; piece_type = 3'd0;
    @(negedge clk); chk("noop.cmd00", busy, 0); cmd = 2'b11;
    @(negedge clk); chk("noop.cmd11", busy, 0); cmd = 2'b01; piece_type = 3'd7;
    @(negedge clk); chk("noop.type7", busy, 0); cmd_valid = 1'b0;

    // Check O rot0 at (4,0): cells (1,5)(1,6)(2,5)(2,6).
    push_rd(1, 1, 5); push_rd(2, 1, 6); push_rd(3, 2, 5); push_rd(4, 2, 6);
    push_res(6, 0, 0);
    run_cmd("chk_O", 2'b01, 3'd1, 2'd0, 4, 0, 1'b0);

    // Lock I rot0 at (3,8): bottom row cols 3..6.
    push_wr(6, 9, 3, 1); push_wr(7, 9, 4, 1); push_wr(8, 9, 5, 1); push_wr(9, 9, 6, 1);
    push_res(10, 0, 0);
    run_cmd("lock_I", 2'b10, 3'd0, 2'd0, 3, 8, 1'b0);
    for (int cc = 2; cc <= 7; cc++) chk("lock_I.grid", grid[9][cc], (cc >= 3 && cc <= 6) ? 1 : 0);
    clear_grid();

    // Lock O onto an occupied cell: collision, no writes; busy commands ignored.
    @(negedge clk); gset = 1'b1; gset_r = 9; gset_c = 5; gset_v = 3'd3;
    @(negedge clk); gset = 1'b0;
    push_res(6, 1, 0);
    run_cmd("lock_O_coll", 2'b10, 3'd1, 2'd0, 4, 7, 1'b1);
    @(negedge clk);
    chk("lock_O_coll.idle_after", busy, 0);
    chk("lock_O_coll.collide_held", collide, 1);
    chk("lock_O_coll.grid_unchanged", grid[8][5], 0);
    clear_grid();

    // Horizontal boundaries.
    push_res(6, 1, 0);
    run_cmd("chk_I_px7", 2'b01, 3'd0, 2'd0, 7, 0, 1'b0);
    push_rd(1, 0, 0); push_rd(2, 1, 0);
    push_res(6, 1, 0);
    run_cmd("chk_I_pxm1", 2'b01, 3'd0, 2'd0, -1, 0, 1'b0);
    push_res(6, 0, 0);
    run_cmd("chk_O_pxm1", 2'b01, 3'd1, 2'd0, -1, 0, 1'b0);

    // Lock O above the top: two cells written on row 0, overflow.
    push_rd(1, 0, 0); push_rd(2, 0, 0); push_rd(3, 0, 5); push_rd(4, 0, 6);
    push_wr(8, 0, 5, 2); push_wr(9, 0, 6, 2);
    push_res(10, 0, 1);
    run_cmd("lock_O_top", 2'b10, 3'd1, 2'd0, 4, -2, 1'b0);

    // Lock L rot2 at (2,3): cells (4,2)(4,3)(4,4)(5,2), value 7.
    push_wr(6, 4, 2, 7); push_wr(7, 4, 3, 7); push_wr(8, 4, 4, 7); push_wr(9, 5, 2, 7);
    push_res(10, 0, 0);
    run_cmd("lock_L_r2", 2'b10, 3'd6, 2'd2, 2, 3, 1'b0);
    clear_grid();

    // Reset during the second write slot of a lock.
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 2'b10; piece_type = 3'd0; rot = 2'd0; px = 5'd0; py = 5'd5;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (6) @(negedge clk);            // cycle 6
    chk("rst_mid.cell0_wr_en", wr_en, 1);
    chk("rst_mid.cell0_row", wr_row, 6);
    @(posedge clk); #1 rst = 1'b1;        // cycle 7
    @(posedge clk); #1 rst = 1'b0;        // cycle 8
    @(negedge clk);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.done", done, 0);
    chk("rst_mid.collide", collide, 0);
    chk("rst_mid.overflow", overflow, 0);
    chk("rst_mid.wr_en", wr_en, 0);
    chk("rst_mid.addr", {rd_row, rd_colum, wr_row, wr_colum}, 0);
    chk("rst_mid.wr_data", wr_data, 0);
    chk("rst_mid.grid_cell0", grid[6][0], 1);
    chk("rst_mid.grid_cell1", grid[6][1], 0);
    chk("rst_mid.grid_cell2", grid[6][2], 0);

    push_res(6, 0, 0);
    run_cmd("after_rst_chk_T", 2'b01, 3'd2, 2'd0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
